// File: rtl/dac_sample_fifo.sv
// Stereo sample FIFO between the synth core and the I2S serializer.
// Pairs are popped once per lrck frame; priming and underrun keep the DAC fed.
module dac_sample_fifo #(
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned START_LEVEL   = 8,
    parameter logic [15:0] SILENCE       = 16'h0000,
    parameter bit          UNDERRUN_HOLD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           in_left,
    input  logic [15:0]           in_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  lrck,
    output logic [15:0]           left,
    output logic [15:0]           right,
    output logic                  sample_tick,
    output logic                  playing,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           underrun_cnt,
    input  logic                  clear_stats
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] START_LVL = (DEPTH_LOG2 + 1)'(START_LEVEL);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                state_q;
    logic                  from_run_q;
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [DEPTH_LOG2-1:0] rptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_d;
    logic [15:0]           left_q;
    logic [15:0]           right_q;
    logic                  tick_q;
    logic                  playing_q;
    logic [15:0]           ucnt_q;
    logic [2:0]            sync_q;

    logic                  frame_evt;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  underrun_evt;
    logic [31:0]           rd_data;

    // Rising edge of the synchronized lrck marks the right half-frame.
    assign frame_evt = sync_q[1] & ~sync_q[2];

    assign empty    = (level_q == '0);
    assign in_ready = rst_n & (level_q != FULL_LVL);
    assign push     = in_valid & in_ready;
    assign pop      = frame_evt & (state_q == ST_RUN) & ~empty;
    assign rd_data  = mem_q[rptr_q];

    // Underrun: an empty frame while running, or a starved frame while
    // re-priming after a previous run (the power-up prime is not counted).
    assign underrun_evt = frame_evt &
        (((state_q == ST_RUN) & empty) |
         ((state_q == ST_PRIME) & (level_q < START_LVL) & from_run_q));

    assign left         = left_q;
    assign right        = right_q;
    assign sample_tick  = tick_q;
    assign playing      = playing_q;
    assign level        = level_q;
    assign underrun_cnt = ucnt_q;

    // Occupancy next state; simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // lrck crosses into clk domain: two sync flops plus an edge-detect flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], lrck};
        end
    end

    // Sample storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_left, in_right};
        end
    end

    // Pointers, occupancy and the underrun statistic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ucnt_q  <= '0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (clear_stats) begin
                ucnt_q <= '0;
            end else if (underrun_evt && ucnt_q != 16'hFFFF) begin
                ucnt_q <= ucnt_q + 16'd1;
            end
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_PRIME;
            from_run_q <= 1'b0;
            playing_q  <= 1'b0;
            tick_q     <= 1'b0;
            left_q     <= SILENCE;
            right_q    <= SILENCE;
        end else begin
            tick_q <= frame_evt;
            case (state_q)
                ST_PRIME: begin
                    if (level_q >= START_LVL) begin
                        state_q   <= ST_RUN;
                        playing_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (frame_evt) begin
                        if (!empty) begin
                            left_q  <= rd_data[31:16];
                            right_q <= rd_data[15:0];
                        end else begin
                            if (!UNDERRUN_HOLD) begin
                                left_q  <= SILENCE;
                                right_q <= SILENCE;
                            end
                            state_q    <= ST_PRIME;
                            playing_q  <= 1'b0;
                            from_run_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_PRIME;
                    playing_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed bench for dac_sample_fifo (silence and hold variants).
// Inputs change 1 ns after posedge; outputs are sampled at the same point.
module tb_dac_sample_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_valid;
    logic        lrck;
    logic        clear_stats;

    logic        in_ready, sample_tick, playing;
    logic [15:0] left, right, underrun_cnt;
    logic [4:0]  level;

    logic        in_ready_h, sample_tick_h, playing_h;
    logic [15:0] left_h, right_h, underrun_cnt_h;
    logic [4:0]  level_h;

    int tests = 0;
    int fails = 0;

    logic        f_tick;
    logic [15:0] f_left;
    logic [15:0] f_right;
    int          ticks;
    logic [15:0] exp_l;

    always #5 clk = ~clk;

    dac_sample_fifo #(.UNDERRUN_HOLD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_left(in_left), .in_right(in_right),
        .in_valid(in_valid), .in_ready(in_ready),
        .lrck(lrck), .left(left), .right(right),
        .sample_tick(sample_tick), .playing(playing),
        .level(level), .underrun_cnt(underrun_cnt),
        .clear_stats(clear_stats)
    );

    dac_sample_fifo #(.UNDERRUN_HOLD(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_left(in_left), .in_right(in_right),
        .in_valid(in_valid), .in_ready(in_ready_h),
        .lrck(lrck), .left(left_h), .right(right_h),
        .sample_tick(sample_tick_h), .playing(playing_h),
        .level(level_h), .underrun_cnt(underrun_cnt_h),
        .clear_stats(clear_stats)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        step();
        in_valid = 1'b0;
    endtask

    // One lrck period; optional push/clear lands on the update edge.
    task automatic frame(input bit psh = 1'b0,
                         input logic [15:0] pl = 16'h0,
                         input logic [15:0] pr = 16'h0,
                         input bit clr = 1'b0);
        lrck = 1'b1;
        step();
        step();
        if (psh) begin
            in_valid = 1'b1;
            in_left  = pl;
            in_right = pr;
        end
        clear_stats = clr;
        step();
        in_valid    = 1'b0;
        clear_stats = 1'b0;
        f_tick  = sample_tick;
        f_left  = left;
        f_right = right;
        lrck = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_left     = '0;
        in_right    = '0;
        in_valid    = 1'b0;
        lrck        = 1'b0;
        clear_stats = 1'b0;
        f_tick      = 1'b0;
        f_left      = '0;
        f_right     = '0;
        ticks       = 0;

        step();
        step();
        check("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", in_ready, 1);
        check("rst_left", left, 16'h0000);
        check("rst_right", right, 16'h0000);
        check("rst_playing", playing, 0);
        check("rst_level", level, 0);
        check("rst_ucnt", underrun_cnt, 0);
        check("rst_tick", sample_tick, 0);

        // Power-up prime: silence, ticks, no underruns.
        for (int i = 0; i < 5; i++) begin
            frame();
            ticks += int'(f_tick);
        end
        check("prime_ticks", ticks, 5);
        check("prime_left", left, 16'h0000);
        check("prime_right", right, 16'h0000);
        check("prime_playing", playing, 0);
        check("prime_ucnt", underrun_cnt, 0);

        // Fill to start level and play out in order.
        for (int n = 0; n < 8; n++) begin
            push(16'h1000 + 16'(n), 16'h2000 + 16'(n));
        end
        check("fill_level", level, 8);
        check("fill_playing_early", playing, 0);
        step();
        check("fill_playing", playing, 1);
        for (int k = 0; k < 8; k++) begin
            frame();
            check("play_tick", f_tick, 1);
            check("play_left", f_left, 16'h1000 + 16'(k));
            check("play_right", f_right, 16'h2000 + 16'(k));
            check("play_level", level, 7 - k);
        end

        // Ninth frame underruns.
        frame();
        check("ur_tick", f_tick, 1);
        check("ur_ucnt", underrun_cnt, 1);
        check("ur_left", f_left, 16'h0000);
        check("ur_right", f_right, 16'h0000);
        check("ur_playing", playing, 0);
        check("hold_left", left_h, 16'h1007);
        check("hold_right", right_h, 16'h2007);
        check("hold_misc", {in_ready_h, sample_tick_h, playing_h},
              3'b100);
        check("hold_level", level_h, 0);
        check("hold_ucnt", underrun_cnt_h, 1);

        for (int n = 0; n < 8; n++) begin
            push(16'h4000 + 16'(n), 16'h5000 + 16'(n));
        end
        step();
        check("refill_playing", playing, 1);
        check("refill_ucnt", underrun_cnt, 1);

        // Hold valid with no frames: exactly 8 more accepted.
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_left  = 16'h3000 + 16'(i);
            in_right = 16'h3100 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        check("full_level", level, 16);
        check("full_ready", in_ready, 0);
        frame();
        check("full_pop_left", f_left, 16'h4000);
        check("full_pop_level", level, 15);
        check("full_pop_ready", in_ready, 1);
        push(16'h6000, 16'h6100);
        check("refull_level", level, 16);

        // Drain to level 5.
        for (int k = 0; k < 11; k++) begin
            exp_l = (k < 7) ? 16'h4001 + 16'(k) : 16'h3000 + 16'(k - 7);
            frame();
            check("drain_left", f_left, exp_l);
        end
        check("drain_level", level, 5);

        // Push and pop on the same edge.
        frame(1'b1, 16'h7000, 16'h7100);
        check("pp_level", level, 5);
        check("pp_left", f_left, 16'h3004);
        check("pp_right", f_right, 16'h3104);
        for (int k = 0; k < 5; k++) begin
            exp_l = (k < 3) ? 16'h3005 + 16'(k) :
                    (k == 3) ? 16'h6000 : 16'h7000;
            frame();
            check("pp_order", f_left, exp_l);
        end
        check("pp_empty", level, 0);

        // Underrun coinciding with clear_stats: clear wins.
        frame(1'b0, 16'h0, 16'h0, 1'b1);
        check("clr_tick", f_tick, 1);
        check("clr_ucnt", underrun_cnt, 0);
        check("clr_playing", playing, 0);
        check("clr_left", f_left, 16'h0000);

        // Re-prime after a run counts starved frames.
        frame();
        check("reprime_ucnt", underrun_cnt, 1);

        // Reset mid-run at level 10.
        for (int n = 0; n < 10; n++) begin
            push(16'h8000 + 16'(n), 16'h9000 + 16'(n));
        end
        step();
        check("pre_rst_level", level, 10);
        check("pre_rst_playing", playing, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_ready", in_ready, 0);
        rst_n = 1'b1;
        check("mid_rst_level", level, 0);
        check("mid_rst_left", left, 16'h0000);
        check("mid_rst_playing", playing, 0);
        check("mid_rst_ucnt", underrun_cnt, 0);
        frame();
        frame();
        check("after_rst_ucnt", underrun_cnt, 0);
        check("after_rst_left", left, 16'h0000);
        check("after_rst_playing", playing, 0);
        check("after_rst_tick", f_tick, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
